bist_control: RTL and testbench
===============================

// Module: bist_control
// PURPOSE
// - Sequencer for a two-phase LFSR/MISR built-in self-test of a circuit under test (CUT).
// - A START rising edge runs a fixed sequence: per phase, load seed, apply N_PATTERNS test
//   cycles, then pulse FINISH. BIST_END flags completion of all phases.
// - Sits between top-level test pins and the LFSR/MISR/CUT datapath; it has no data path of its own.
// PARAMETERS
// N_PATTERNS  20  test cycles per phase (>=1); counter width = $clog2(N_PATTERNS+1)
// N_PHASES    2   number of phases (1 or 2); phase index drives Poly
// PORTS
// CLK       in   1  single clock, rising edge
// RESET     in   1  asynchronous, active-high reset
// START     in   1  synchronous request; only a 0->1 transition starts a run
// OUT       out  1  1 = CUT in test mode; patterns applied this cycle
// BIST_END  out  1  1 = all phases done; held until RESET or a new START edge
// Poly      out  1  LFSR/MISR polynomial select = current phase index (0 or 1)
// Seed      out  1  one-cycle pulse: load LFSR seed and clear MISR
// FINISH    out  1  one-cycle pulse at end of each phase: capture/compare signature
// BEHAVIOUR
// - Interface: one clock; RESET is asynchronous and active-high. All outputs are registered Moore
//   decodes of the state; no combinational input->output paths.
// - Reset: state=IDLE, phase=0, count=0, start_q=0; all outputs 0.
// - Edge detect: start_q <= START every cycle. start_edge = START & ~start_q. START held high
//   across reset release counts as one edge.
// - States:
//   IDLE : all outputs 0. start_edge -> LOAD, phase=0.
//   LOAD : Seed=1, Poly=phase, OUT=0. Next cycle -> RUN, count=0.
//   RUN  : OUT=1, Poly=phase, count++. Leaves after exactly N_PATTERNS cycles -> CHECK.
//   CHECK: FINISH=1, Poly=phase, OUT=0. If phase<N_PHASES-1: phase++, -> LOAD. Else -> DONE.
//   DONE : BIST_END=1, all other outputs 0. start_edge -> LOAD, phase=0, BIST_END clears.
// - Latency: the first LOAD cycle starts at the clock edge after start_edge. Each phase lasts
//   N_PATTERNS+2 cycles. BIST_END rises N_PHASES*(N_PATTERNS+2) cycles after that edge.
// - START edges in LOAD/RUN/CHECK are ignored; a run is never restarted or extended.
// - START held high through the whole run triggers no second run; it must drop first.
// - At most one of Seed/OUT/FINISH/BIST_END is 1 in any cycle.
// - RESET mid-run aborts immediately: outputs 0, IDLE. No FINISH or BIST_END is produced.
// TESTING
// - Reset: RESET=1 with START toggling -> all outputs 0 throughout; IDLE after release.
// - Full run (defaults): START 0->1 held 2 cycles -> Seed 1 cycle (Poly=0), OUT 20 cycles,
//   FINISH 1 cycle, Seed (Poly=1), OUT 20 cycles, FINISH, then BIST_END=1 44 cycles after the edge.
// - Ignored restarts: extra START pulses during RUN -> sequence and cycle counts unchanged.
// - Level START: START held high from before completion -> BIST_END stays 1, no rerun. Drop then
//   raise START -> new run, BIST_END clears on the next edge.
// - Abort: RESET asserted in phase 1 RUN (cycle 30) -> outputs 0 asynchronously. START after
//   release -> full 44-cycle run from phase 0.
// - Exclusivity check: assert onehot0{Seed,OUT,FINISH,BIST_END} every cycle. Assert Seed/FINISH
//   pulses are exactly 1 cycle wide.

Source files
------------

// File: rtl/bist_control.sv
// Two-phase LFSR/MISR BIST sequencer: START edge -> (Seed, N_PATTERNS x OUT, FINISH) per phase, then BIST_END.
// Registered Moore outputs, first Seed one edge after START is seen; no backpressure, START edges mid-run are ignored.
module bist_control #(
  parameter int N_PATTERNS = 20,
  parameter int N_PHASES   = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic START,
  output logic OUT,
  output logic BIST_END,
  output logic Poly,
  output logic Seed,
  output logic FINISH
);

  localparam int CW = $clog2(N_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic          phase, phase_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          start_q;
  logic          start_edge;
  logic          last_phase;

  assign start_edge = START & ~start_q;
  assign last_phase = (N_PHASES < 2) || phase;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    count_nxt = count;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_nxt = LOAD;
          phase_nxt = 1'b0;
        end
      end
      LOAD: begin
        state_nxt = RUN;
        count_nxt = '0;
      end
      RUN: begin
        count_nxt = count + 1'b1;
        if (count == LAST_CNT) state_nxt = CHECK;
      end
      CHECK: begin
        if (last_phase) begin
          state_nxt = DONE;
        end else begin
          state_nxt = LOAD;
          phase_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      phase    <= 1'b0;
      count    <= '0;
      start_q  <= 1'b0;
      OUT      <= 1'b0;
      BIST_END <= 1'b0;
      Poly     <= 1'b0;
      Seed     <= 1'b0;
      FINISH   <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      count    <= count_nxt;
      start_q  <= START;
      OUT      <= (state_nxt == RUN);
      BIST_END <= (state_nxt == DONE);
      Seed     <= (state_nxt == LOAD);
      FINISH   <= (state_nxt == CHECK);
      Poly     <= phase_nxt & ((state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == CHECK));
    end
  end

endmodule

// File: tb/tb_bist_control.sv
// Directed bench for bist_control: reset, full runs, ignored restarts, level START, abort, reset-release edge.
module tb_bist_control;

  logic CLK;
  logic RESET;
  logic START;
  logic OUT;
  logic BIST_END;
  logic Poly;
  logic Seed;
  logic FINISH;

  int total = 0;
  int bad   = 0;

  logic prev_seed   = 1'b0;
  logic prev_finish = 1'b0;

  bist_control #(
    .N_PATTERNS(20),
    .N_PHASES  (2)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .OUT     (OUT),
    .BIST_END(BIST_END),
    .Poly    (Poly),
    .Seed    (Seed),
    .FINISH  (FINISH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {Seed, OUT, FINISH, BIST_END, Poly}
  function automatic logic [4:0] outs();
    return {Seed, OUT, FINISH, BIST_END, Poly};
  endfunction

  // Hand timeline for 20 patterns x 2 phases; k = negedge index after the capturing edge.
  function automatic logic [4:0] exp_at(input int k);
    if (k == 0)       return 5'b10000;
    else if (k <= 20) return 5'b01000;
    else if (k == 21) return 5'b00100;
    else if (k == 22) return 5'b10001;
    else if (k <= 42) return 5'b01001;
    else if (k == 43) return 5'b00101;
    else              return 5'b00010;
  endfunction

  // Checks ncyc cycles of a run; start_pat[k] is the START level driven after cycle k.
  task automatic run_seq(input string tag, input int ncyc, input logic [63:0] start_pat);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLK);
      check_eq($sformatf("%s_k%0d", tag, k), {27'b0, outs()}, {27'b0, exp_at(k)});
      if (k < 64) START = start_pat[k];
    end
  endtask

  task automatic expect_quiet(input string tag, input int ncyc, input logic [4:0] exp);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      check_eq($sformatf("%s_%0d", tag, i), {27'b0, outs()}, {27'b0, exp});
    end
  endtask

  // Exclusivity and pulse-width monitor.
  always @(negedge CLK) begin
    check_eq("onehot0", {31'b0, $onehot0({Seed, OUT, FINISH, BIST_END})}, 32'd1);
    check_eq("seed_width", {31'b0, Seed & prev_seed}, 32'd0);
    check_eq("finish_width", {31'b0, FINISH & prev_finish}, 32'd0);
    prev_seed   = Seed;
    prev_finish = FINISH;
  end

  initial begin
    RESET = 1'b1;
    START = 1'b0;

    // Reset with START toggling: outputs stay low.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check_eq($sformatf("rst_%0d", i), {27'b0, outs()}, 32'd0);
      START = ~START;
    end
    @(negedge CLK);
    START = 1'b0;
    RESET = 1'b0;
    expect_quiet("idle", 3, 5'b00000);

    // Full run, START held for two cycles.
    @(negedge CLK);
    START = 1'b1;
    run_seq("full", 48, 64'h1);

    // Extra START pulses during RUN are ignored.
    @(negedge CLK);
    START = 1'b1;
    run_seq("restart", 48, 64'h0000_0000_4000_0081);

    // START held high through the run: no second run.
    @(negedge CLK);
    START = 1'b1;
    run_seq("level", 50, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_quiet("level_hold", 3, 5'b00010);
    START = 1'b0;
    expect_quiet("level_drop", 2, 5'b00010);
    @(negedge CLK);
    START = 1'b1;
    run_seq("rerun", 46, 64'h1);

    // Abort in phase 1 RUN at cycle 30.
    @(negedge CLK);
    START = 1'b1;
    run_seq("abort", 31, 64'h1);
    #2 RESET = 1'b1;
    #1 check_eq("abort_async", {27'b0, outs()}, 32'd0);
    expect_quiet("abort_rst", 2, 5'b00000);
    @(negedge CLK);
    RESET = 1'b0;
    expect_quiet("abort_idle", 2, 5'b00000);
    @(negedge CLK);
    START = 1'b1;
    run_seq("post_abort", 48, 64'h1);

    // START high across reset release counts as an edge.
    @(negedge CLK);
    RESET = 1'b1;
    START = 1'b1;
    expect_quiet("rst_start", 1, 5'b00000);
    @(negedge CLK);
    RESET = 1'b0;
    run_seq("rst_edge", 4, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
